// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared encodings for the cache AXI read arbiter: FSM states, grant
// encoding, AXI AR constants and default transaction IDs.
package cache_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Grant encoding: 0 selects the icache, 1 selects the dcache.
    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    localparam logic [3:0] ID_IC_DEF      = 4'd0;
    localparam logic [3:0] ID_DC_DEF      = 4'd1;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic logic [3:0] grant_id(input logic gnt,
                                            input logic [3:0] id_ic,
                                            input logic [3:0] id_dc);
        return (gnt == GNT_DC) ? id_dc : id_ic;
    endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter_rr_arb2.sv
// Two-requester round-robin grant: on a tie the requester that did not win
// last time is chosen. Purely combinational.
module rr_arb2
    import cache_axi_rd_arbiter_pkg::*;
(
    input  logic req_ic,
    input  logic req_dc,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt
);

    always_comb begin
        gnt_valid = req_ic | req_dc;
        if (req_ic && req_dc) begin
            gnt = ~last_grant;
        end else if (req_dc) begin
            gnt = GNT_DC;
        end else begin
            gnt = GNT_IC;
        end
    end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read port between icache and dcache: round-robin grant, one
// outstanding burst at a time, R beats steered back and checked for protocol errors.
module cache_axi_rd_arbiter
    import cache_axi_rd_arbiter_pkg::*;
#(
    parameter logic [3:0] ID_IC    = ID_IC_DEF,
    parameter logic [3:0] ID_DC    = ID_DC_DEF,
    parameter logic [2:0] AR_SIZE  = AXI_SIZE_4B,
    parameter logic [1:0] AR_BURST = AXI_BURST_INCR
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ic_araddr,
    input  logic [7:0]  ic_arlen,
    input  logic        ic_arvalid,
    output logic        ic_arready,
    output logic [31:0] ic_rdata,
    output logic        ic_rvalid,
    output logic        ic_rlast,
    input  logic        ic_rready,

    input  logic [31:0] dc_araddr,
    input  logic [7:0]  dc_arlen,
    input  logic        dc_arvalid,
    output logic        dc_arready,
    output logic [31:0] dc_rdata,
    output logic        dc_rvalid,
    output logic        dc_rlast,
    input  logic        dc_rready,

    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [3:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,

    output logic        rd_err
);

    state_t      state;
    state_t      state_nxt;
    logic        grant;
    logic        last_grant;
    logic [7:0]  beat_cnt;
    logic [7:0]  len_r;
    logic        arb_valid;
    logic        arb_gnt;
    logic        r_hs;
    logic        beat_err;
    logic [3:0]  cur_id;

    rr_arb2 u_rr_arb2 (
        .req_ic     (ic_arvalid),
        .req_dc     (dc_arvalid),
        .last_grant (last_grant),
        .gnt_valid  (arb_valid),
        .gnt        (arb_gnt)
    );

    assign m_arsize  = AR_SIZE;
    assign m_arburst = AR_BURST;

    assign cur_id = grant_id(grant, ID_IC, ID_DC);
    assign r_hs   = (state == ST_DATA) && m_rvalid && m_rready;

    // A beat is bad if rlast disagrees with the count, or the ID/response is wrong.
    assign beat_err = (m_rlast != (beat_cnt == len_r)) ||
                      (m_rid != cur_id) ||
                      (m_rresp != 2'b00);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (arb_valid)         state_nxt = ST_ADDR;
            ST_ADDR: if (m_arready)         state_nxt = ST_DATA;
            ST_DATA: if (r_hs && m_rlast)   state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= GNT_IC;
            last_grant <= GNT_DC;
            beat_cnt   <= 8'd0;
            len_r      <= 8'd0;
            rd_err     <= 1'b0;
        end else begin
            if (state == ST_IDLE && arb_valid) begin
                grant    <= arb_gnt;
                len_r    <= (arb_gnt == GNT_DC) ? dc_arlen : ic_arlen;
                beat_cnt <= 8'd0;
            end
            if (state == ST_ADDR && m_arready) begin
                last_grant <= grant;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (beat_err) begin
                    rd_err <= 1'b1;
                end
            end
        end
    end

    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        m_arvalid  = 1'b0;
        m_arid     = 4'd0;
        m_araddr   = 32'd0;
        m_arlen    = 8'd0;
        m_rready   = 1'b0;
        ic_arready = 1'b0;
        dc_arready = 1'b0;
        ic_rvalid  = 1'b0;
        ic_rlast   = 1'b0;
        ic_rdata   = 32'd0;
        dc_rvalid  = 1'b0;
        dc_rlast   = 1'b0;
        dc_rdata   = 32'd0;
        case (state)
            ST_ADDR: begin
                m_arvalid  = 1'b1;
                m_arid     = cur_id;
                m_araddr   = (grant == GNT_DC) ? dc_araddr : ic_araddr;
                m_arlen    = (grant == GNT_DC) ? dc_arlen  : ic_arlen;
                ic_arready = (grant == GNT_IC) && m_arready;
                dc_arready = (grant == GNT_DC) && m_arready;
            end
            ST_DATA: begin
                m_rready  = (grant == GNT_DC) ? dc_rready : ic_rready;
                ic_rvalid = (grant == GNT_IC) && m_rvalid;
                ic_rlast  = (grant == GNT_IC) && m_rlast;
                dc_rvalid = (grant == GNT_DC) && m_rvalid;
                dc_rlast  = (grant == GNT_DC) && m_rlast;
                ic_rdata  = m_rdata;
                dc_rdata  = m_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cache_axi_rd_arbiter.md
Name: cache_axi_rd_arbiter

Overview:
- Shares a single AXI read port (AR/R channels) between the instruction cache and the data cache miss/uncached engines.
- Grants one outstanding read transaction at a time, using round-robin arbitration.
- Drives the AXI AR fields and steers R beats back to the granted cache.
- Counts beats against the requested length and flags protocol mismatches.
- Sits between the two caches and the CPU-top AXI interface.

Parameters:
- ID_IC, 4'd0, arid used for instruction-cache transactions
- ID_DC, 4'd1, arid used for data-cache transactions
- AR_SIZE, 3'b010, arsize driven on every request (4 bytes/beat)
- AR_BURST, 2'b01, arburst driven on every request (INCR)

Ports:
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- ic_araddr  in  32  icache read address, held stable while ic_arvalid
- ic_arlen  in  8  beats-1 (7 for a cached line, 0 for uncached)
- ic_arvalid  in  1  icache request
- ic_arready  out  1  icache address accepted
- ic_rdata  out  32  read beat data
- ic_rvalid  out  1  beat valid to icache
- ic_rlast  out  1  last beat to icache
- ic_rready  in  1  icache can take a beat
- dc_araddr, dc_arlen, dc_arvalid, dc_arready, dc_rdata, dc_rvalid, dc_rlast, dc_rready: same widths and meanings as the ic_ ports, for the dcache
- m_arid  out  4  AXI arid
- m_araddr  out  32  AXI araddr
- m_arlen  out  8  AXI arlen
- m_arsize  out  3  AR_SIZE
- m_arburst  out  2  AR_BURST
- m_arvalid  out  1  AXI arvalid
- m_arready  in  1  AXI arready
- m_rid  in  4  AXI rid
- m_rdata  in  32  AXI rdata
- m_rresp  in  2  AXI rresp (checked, not forwarded)
- m_rlast  in  1  AXI rlast
- m_rvalid  in  1  AXI rvalid
- m_rready  out  1  AXI rready
- rd_err  out  1  sticky protocol-error flag

Behaviour:
- States: IDLE, ADDR, DATA.
- Registers: state, grant (0=IC, 1=DC), last_grant, beat_cnt[7:0], len_r[7:0], rd_err.
- Reset (rst=0, asynchronous): state=IDLE, grant=0, last_grant=DC (so IC wins the first tie), beat_cnt=0, len_r=0, rd_err=0. While in reset, all outputs are 0 except m_arsize/m_arburst, which are the constants.
- IDLE:
  - Only ic_arvalid is high: grant<=IC.
  - Only dc_arvalid is high: grant<=DC.
  - Both are high: grant<=~last_grant.
  - On any grant: len_r<=granted arlen, beat_cnt<=0, state<=ADDR.
  - Neither is high: stay in IDLE.
  - No ready/valid is driven in IDLE.
- ADDR:
  - m_arvalid=1. m_araddr, m_arlen and m_arid are muxed combinationally from the granted requester / ID param.
  - Granted *_arready = m_arready. The ungranted *_arready is held at 0.
  - On m_arready: state<=DATA, last_grant<=grant.
  - Address appears on AXI one cycle after the request is first seen in IDLE.
- DATA:
  - m_rready = granted *_rready.
  - Granted *_rvalid = m_rvalid; *_rlast = m_rlast; *_rdata = m_rdata.
  - Ungranted *_rvalid/*_rlast are held at 0. Both *_rdata outputs carry m_rdata (don't-care when not valid).
  - Each handshake (m_rvalid & m_rready) increments beat_cnt, which wraps at 8 bits.
  - Handshake with m_rlast: state<=IDLE.
- Error detection (sets rd_err<=1; it stays 1 until reset):
  - rlast arrives with beat_cnt!=len_r.
  - beat_cnt==len_r arrives without rlast.
  - m_rid!=granted ID on any handshake.
  - m_rresp!=0 on any handshake.
  - The transaction still completes normally after an error.
- m_rready=0 outside DATA. Stray R beats outside DATA are not consumed.
- Back-to-back operation: exactly one IDLE cycle follows the last beat before the next m_arvalid.
- Arbitration: a requester deasserting arvalid before arready is a requester error and is not checked; the arbiter keeps the grant until the AR handshake.
- Cache flush does not abort a granted burst; all beats are drained to the cache.
- Reset asserted mid-burst returns the block to IDLE immediately. The AXI slave is reset by the same rst.

Decomposition:
- defines.vh holds: state encodings (IDLE/ADDR/DATA), AXI_BURST_INCR, AXI_SIZE_4B, ID_IC/ID_DC defaults.
- One sub-module, rr_arb2: a 2-requester round-robin grant with a last_grant input. It is pure combinational, instantiated once.

Test Plan:
- IC only, ic_araddr=0xBFC0_0000, arlen=7; slave arready after 2 cycles, 8 beats 0x0..0x7 → m_arid=0, m_arlen=7, ic_rvalid for 8 beats, ic_rlast on the 8th, rd_err=0, dc_rvalid never 1.
- IC and DC both raise arvalid in the same cycle from reset → IC granted first (m_arid=0); after its rlast, one IDLE cycle, then DC (m_arid=1). The next tie grants IC again.
- DC uncached, dc_araddr=0x1FAF_F000, arlen=0; single beat 0xDEAD_BEEF with rlast → dc_rdata=0xDEAD_BEEF, dc_rlast=1, return to IDLE, rd_err=0.
- IC burst arlen=7 where the slave asserts rlast on beat 6 → rd_err=1 after that beat, state IDLE; rd_err stays 1 through a following clean DC transaction.
- ic_rready held 0 for 3 cycles mid-burst → m_rready=0 during those cycles, beat_cnt frozen, all 8 beats delivered in order.
- rst driven low asynchronously during beat 4 of a burst → m_arvalid=0, m_rready=0, state IDLE with no clock edge. After release, a fresh IC request is granted normally.
